// File: rtl/alu_operand_stage.sv
`timescale 1ns/1ps
// Operand/control register stage in front of the ALU: bus-writable op0/op1/cr,
// a CR write launches a fixed settle window, then the ALU result is captured.
module alu_operand_stage #(
  parameter int         DATA_WIDTH    = 8,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] A_DR0         = 4'h1,
  parameter logic [3:0] A_DR1         = 4'h2,
  parameter logic [3:0] A_CR          = 4'h3,
  parameter logic [3:0] A_ST          = 4'h4,
  parameter logic [3:0] A_RQ          = 4'h5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] addr_bus,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  input  logic [DATA_WIDTH-1:0] alu_re,
  output logic [DATA_WIDTH-1:0] op0,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] cr,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op0_q, op0_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] cr_q, cr_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [3:0] code;
  logic       capture;
  logic       err_set;
  logic       unused_addr;

  assign code        = addr_bus[7:4];
  assign unused_addr = ^addr_bus;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    cr_d    = cr_q;
    res_d   = res_q;
    capture = 1'b0;
    err_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          case (code)
            A_DR0: op0_d = data_bus_in;
            A_DR1: op1_d = data_bus_in;
            A_CR: begin
              cr_d    = data_bus_in;
              cnt_d   = SETTLE_LOAD;
              state_d = S_EXEC;
            end
            default: ;
          endcase
        end
      end
      default: begin
        // Register writes during the settle window would corrupt the ALU inputs.
        if (wr_en && (code == A_DR0 || code == A_DR1 || code == A_CR)) err_set = 1'b1;
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          res_d   = alu_re;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase

    // Setting a flag wins over the read that would clear it.
    if (capture)                          done_d = 1'b1;
    else if (rd_en && code == A_RQ)       done_d = 1'b0;
    else                                  done_d = done_q;

    if (err_set)                          err_d = 1'b1;
    else if (rd_en && code == A_ST)       err_d = 1'b0;
    else                                  err_d = err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
      cr_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      cr_q    <= cr_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign op0  = op0_q;
  assign op1  = op1_q;
  assign cr   = cr_q;
  assign busy = (state_q == S_EXEC);
  assign done = done_q;

  // Zero when unselected so the output can be OR-merged with the ALU's read bus.
  always_comb begin
    data_bus_out = '0;
    if (rd_en) begin
      case (code)
        A_DR0:   data_bus_out = op0_q;
        A_DR1:   data_bus_out = op1_q;
        A_CR:    data_bus_out = cr_q;
        A_ST:    data_bus_out = {{(DATA_WIDTH-3){1'b0}}, err_q, done_q, busy};
        A_RQ:    data_bus_out = res_q;
        default: data_bus_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
`timescale 1ns/1ps
// Bench for alu_operand_stage: unit 0 uses SETTLE_CYCLES=1, unit 1 uses 4;
// a cycle-level reference model tracks both units alongside directed and random stimulus.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       rst_s [2];
  logic       wr_s  [2];
  logic       rd_s  [2];
  logic [7:0] addr_s[2];
  logic [7:0] din_s [2];
  logic [7:0] alu_s [2];
  logic [7:0] op0_s [2];
  logic [7:0] op1_s [2];
  logic [7:0] cr_s  [2];
  logic [7:0] dbo_s [2];
  logic       busy_s[2];
  logic       done_s[2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Simple ALU stand-in: cr[1:0] selects add, sub, and, xor.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    case (c[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_s[0] = alu_fn(op0_s[0], op1_s[0], cr_s[0]);
  assign alu_s[1] = alu_fn(op0_s[1], op1_s[1], cr_s[1]);

  alu_operand_stage #(.DATA_WIDTH(8), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst_s[0]), .addr_bus(addr_s[0]), .wr_en(wr_s[0]), .rd_en(rd_s[0]),
    .data_bus_in(din_s[0]), .alu_re(alu_s[0]), .op0(op0_s[0]), .op1(op1_s[0]), .cr(cr_s[0]),
    .data_bus_out(dbo_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  alu_operand_stage #(.DATA_WIDTH(8), .SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst_s[1]), .addr_bus(addr_s[1]), .wr_en(wr_s[1]), .rd_en(rd_s[1]),
    .data_bus_in(din_s[1]), .alu_re(alu_s[1]), .op0(op0_s[1]), .op1(op1_s[1]), .cr(cr_s[1]),
    .data_bus_out(dbo_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  // Reference model: architectural registers plus edges remaining until capture.
  logic [7:0] m_op0[2], m_op1[2], m_cr[2], m_res[2];
  logic       m_done[2], m_err[2];
  int         m_left[2];

  function automatic int settle(input int v);
    return (v == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] m_read(input int v, input logic rd, input logic [7:0] a);
    if (!rd) return 8'h00;
    case (a[7:4])
      4'h1:    return m_op0[v];
      4'h2:    return m_op1[v];
      4'h3:    return m_cr[v];
      4'h4:    return {5'b0, m_err[v], m_done[v], (m_left[v] > 0)};
      4'h5:    return m_res[v];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_step(input int v, input logic r, input logic w, input logic rd,
                        input logic [7:0] a, input logic [7:0] d);
    logic cap, eset;
    logic [3:0] c;
    c = a[7:4];
    cap = 1'b0;
    eset = 1'b0;
    if (r) begin
      m_op0[v] = 0; m_op1[v] = 0; m_cr[v] = 0; m_res[v] = 0;
      m_done[v] = 0; m_err[v] = 0; m_left[v] = 0;
    end else begin
      if (m_left[v] > 0) begin
        if (w && (c == 4'h1 || c == 4'h2 || c == 4'h3)) eset = 1'b1;
        m_left[v] = m_left[v] - 1;
        if (m_left[v] == 0) begin
          cap = 1'b1;
          m_res[v] = alu_fn(m_op0[v], m_op1[v], m_cr[v]);
        end
      end else if (w) begin
        if (c == 4'h1) m_op0[v] = d;
        if (c == 4'h2) m_op1[v] = d;
        if (c == 4'h3) begin m_cr[v] = d; m_left[v] = settle(v); end
      end
      if (cap) m_done[v] = 1'b1;
      else if (rd && c == 4'h5) m_done[v] = 1'b0;
      if (eset) m_err[v] = 1'b1;
      else if (rd && c == 4'h4) m_err[v] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock on unit u (the other unit idles); returns pre-edge dbo/busy/done of unit u.
  task automatic cycle(input int u, input logic r, input logic w, input logic rd,
                       input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] q, output logic qb, output logic qd);
    @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      rst_s[v]  = (v == u) ? r  : 1'b0;
      wr_s[v]   = (v == u) ? w  : 1'b0;
      rd_s[v]   = (v == u) ? rd : 1'b0;
      addr_s[v] = (v == u) ? a  : 8'h00;
      din_s[v]  = (v == u) ? d  : 8'h00;
    end
    #1;
    q = dbo_s[u]; qb = busy_s[u]; qd = done_s[u];
    for (int v = 0; v < 2; v++) begin
      check($sformatf("u%0d dbo", v),  dbo_s[v],  m_read(v, rd_s[v], addr_s[v]));
      check($sformatf("u%0d busy", v), busy_s[v], m_left[v] > 0);
      check($sformatf("u%0d done", v), done_s[v], m_done[v]);
      check($sformatf("u%0d op0", v),  op0_s[v],  m_op0[v]);
      check($sformatf("u%0d op1", v),  op1_s[v],  m_op1[v]);
      check($sformatf("u%0d cr", v),   cr_s[v],   m_cr[v]);
    end
    for (int v = 0; v < 2; v++) m_step(v, rst_s[v], wr_s[v], rd_s[v], addr_s[v], din_s[v]);
    @(posedge clk);
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dbo;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [7:0] q;
    logic qb, qd;
    logic [7:0] codes[7];

    // Expected values are pre-edge observations of unit 0 (SETTLE_CYCLES=1).
    tbl[0]  = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h10, 8'h05, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h20, 8'h03, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h01, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h50, 8'h00, 8'h08, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h05, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h20, 8'h00, 8'h03, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'hF0, 8'hAA, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h05, 1'b0, 1'b0};

    for (int v = 0; v < 2; v++) begin
      rst_s[v] = 1'b1; wr_s[v] = 1'b0; rd_s[v] = 1'b0; addr_s[v] = 8'h00; din_s[v] = 8'h00;
    end
    repeat (2) @(posedge clk);
    for (int v = 0; v < 2; v++) m_step(v, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 17; i++) begin
      cycle(0, 1'b0, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].din, q, qb, qd);
      check($sformatf("tbl%0d dbo", i),  q,  tbl[i].dbo);
      check($sformatf("tbl%0d busy", i), qb, tbl[i].busy);
      check($sformatf("tbl%0d done", i), qd, tbl[i].done);
    end

    // Unit 0: result read on the exact capture edge keeps done set.
    cycle(0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h03, q, qb, qd);
    cycle(0, 1'b0, 1'b0, 1'b1, 8'h50, 8'h00, q, qb, qd);
    check("capread old res", q, 8'h08);
    #1 check("capread done kept", done_s[0], 1'b1);
    cycle(0, 1'b0, 1'b0, 1'b1, 8'h50, 8'h00, q, qb, qd);
    check("capread new res", q, 8'h06);
    #1 check("capread done cleared", done_s[0], 1'b0);

    // Unit 1 (SETTLE_CYCLES=4): write dropped during settle sets err only.
    cycle(1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, q, qb, qd);
    cycle(1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h20, q, qb, qd);
    cycle(1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h01, q, qb, qd);
    cycle(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    check("s4 busy c1", qb, 1'b1);
    cycle(1, 1'b0, 1'b1, 1'b0, 8'h10, 8'hFF, q, qb, qd);
    cycle(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    cycle(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    check("s4 busy c4", qb, 1'b1);
    #1 check("s4 op0 unchanged", op0_s[1], 8'h10);
    check("s4 busy after", busy_s[1], 1'b0);
    cycle(1, 1'b0, 1'b0, 1'b1, 8'h40, 8'h00, q, qb, qd);
    check("s4 status err+done", q, 8'h06);
    cycle(1, 1'b0, 1'b0, 1'b1, 8'h40, 8'h00, q, qb, qd);
    check("s4 status err cleared", q, 8'h02);
    cycle(1, 1'b0, 1'b0, 1'b1, 8'h50, 8'h00, q, qb, qd);
    check("s4 result", q, 8'hF0);

    // Unit 1: reset during EXEC abandons the operation.
    cycle(1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h00, q, qb, qd);
    cycle(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    cycle(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    #1;
    check("rst busy", busy_s[1], 1'b0);
    check("rst done", done_s[1], 1'b0);
    check("rst cr", cr_s[1], 8'h00);
    repeat (6) cycle(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);
    check("rst no capture", done_s[1], 1'b0);
    cycle(1, 1'b0, 1'b0, 1'b1, 8'h50, 8'h00, q, qb, qd);
    check("rst res zero", q, 8'h00);

    // Randomized traffic on both units, checked against the model every cycle.
    codes[0] = 8'h00; codes[1] = 8'h10; codes[2] = 8'h20; codes[3] = 8'h30;
    codes[4] = 8'h40; codes[5] = 8'h50; codes[6] = 8'hF0;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = codes[$urandom_range(0, 6)] | 8'($urandom_range(0, 15));
      cycle($urandom_range(0, 1), ($urandom_range(0, 63) == 0), 1'($urandom),
            1'($urandom), a, 8'($urandom), q, qb, qd);
    end
    repeat (6) cycle(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, q, qb, qd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
